// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the fault-cause code reported on the debug port.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_ILLEGAL  = 2'd2,
        FC_TIMEOUT  = 2'd3
    } lsu_fault_t;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: request legality/alignment, byte enables and
// store steering on the request side; lane extraction and extension on loads.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata_lane,
    output logic        req_error,
    output logic [1:0]  req_cause,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic        legal;
    logic        misalign;
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        legal    = 1'b0;
        misalign = 1'b0;
        // Read and write together is never legal, whatever funct3 says.
        case ({req_read, req_write})
            2'b10:   legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H) ||
                             (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                             (req_funct3 == F3_HU);
            2'b01:   legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H) ||
                             (req_funct3 == F3_W);
            default: legal = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b01:   misalign = req_addr_lo[0];
            2'b10:   misalign = (req_addr_lo != 2'b00);
            default: misalign = 1'b0;
        endcase
        req_error = !legal || misalign;
        if (!legal)
            req_cause = FC_ILLEGAL;
        else if (misalign)
            req_cause = FC_MISALIGN;
        else
            req_cause = FC_NONE;
    end

    always_comb begin
        req_be         = 4'b0000;
        req_wdata_lane = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                req_be         = 4'b0001 << req_addr_lo;
                req_wdata_lane = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be         = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                req_wdata_lane = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                req_be         = 4'b1111;
                req_wdata_lane = req_wdata;
            end
            default: begin
                req_be         = 4'b0000;
                req_wdata_lane = req_wdata;
            end
        endcase
    end

    always_comb begin
        shifted = ld_word >> {ld_addr_lo, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: turns a held mem_read/mem_write level into one
// req/ack bus transaction and returns a one-cycle done (with fault).
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write; error requests go straight to RESP
// BUS    | bus_req high, bus_* stable, counting cycles toward timeout
// RESP   | done (and fault) high for this single cycle, requests ignored
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state;
    logic [7:0]  cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic [3:0]  req_be;
    logic [31:0] req_wdata_lane;
    logic        req_error;
    logic [1:0]  req_cause;
    logic [31:0] ld_data;

    lsu_lane u_lane (
        .req_read       (mem_read),
        .req_write      (mem_write),
        .req_funct3     (funct3),
        .req_addr_lo    (addr[1:0]),
        .req_wdata      (wdata),
        .req_be         (req_be),
        .req_wdata_lane (req_wdata_lane),
        .req_error      (req_error),
        .req_cause      (req_cause),
        .ld_funct3      (funct3_q),
        .ld_addr_lo     (addr_lo_q),
        .ld_word        (bus_rdata),
        .ld_data        (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            rdata       <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_be      <= 4'd0;
            bus_wdata   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_read || mem_write) begin
                        busy        <= 1'b1;
                        fault_cause <= req_cause;
                        if (req_error) begin
                            done  <= 1'b1;
                            fault <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= req_be;
                            bus_wdata <= req_wdata_lane;
                            funct3_q  <= funct3;
                            addr_lo_q <= addr[1:0];
                            cnt       <= 8'd0;
                            state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // An ack in the last allowed cycle still counts as success.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            rdata <= ld_data;
                        done  <= 1'b1;
                        fault <= 1'b0;
                        state <= S_RESP;
                    end else if (cnt == TMO_LAST) begin
                        bus_req     <= 1'b0;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= FC_TIMEOUT;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus
// requests and responses; a negedge monitor pops and compares them.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_cause (fault_cause),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        logic [1:0]  cause;
    } resp_exp_t;

    localparam logic [1:0] C_NONE = 2'd0, C_MIS = 2'd1, C_ILL = 2'd2, C_TMO = 2'd3;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata = 32'd0;
    logic        prev_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare bus request contents on bus_req rise, response on done.
    always @(negedge clk) begin
        if (bus_req && !prev_req) begin
            if (bus_q.size() == 0) begin
                check("unexpected_bus_req", 32'd1, 32'd0);
            end else begin
                bus_exp_t b;
                b = bus_q.pop_front();
                check("bus_addr", bus_addr, b.addr);
                check("bus_be", {28'd0, bus_be}, {28'd0, b.be});
                check("bus_we", {31'd0, bus_we}, {31'd0, b.we});
                if (b.chk_wdata)
                    check("bus_wdata", bus_wdata, b.wdata);
            end
        end
        prev_req = bus_req;
        if (done) begin
            if (resp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                resp_exp_t r;
                r = resp_q.pop_front();
                check("resp_fault", {31'd0, fault}, {31'd0, r.fault});
                check("resp_rdata", rdata, r.rdata);
                check("resp_busy", {31'd0, busy}, 32'd1);
                if (r.fault)
                    check("resp_cause", {30'd0, fault_cause}, {30'd0, r.cause});
            end
        end
    end

    // ack_at: BUS cycle (1-based) carrying bus_ack; 0 means never ack.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_at,
                             input logic [31:0] brd, input logic e_fault,
                             input logic [1:0] e_cause, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        bus_exp_t  b;
        resp_exp_t r;
        int  lat, reqc, e_lat, e_reqc;
        logic got, issued;
        issued = (e_cause == C_NONE) || (e_cause == C_TMO);
        if (issued) begin
            b.addr = {a[31:2], 2'b00};
            b.be = e_be;
            b.we = wr;
            b.wdata = e_wdata;
            b.chk_wdata = wr;
            bus_q.push_back(b);
            e_lat  = (ack_at != 0) ? ack_at + 1 : TIMEOUT + 1;
            e_reqc = (ack_at != 0) ? ack_at : TIMEOUT;
        end else begin
            e_lat  = 1;
            e_reqc = 0;
        end
        if (rd && !wr && !e_fault)
            exp_rdata = e_rdata;
        r.fault = e_fault;
        r.rdata = exp_rdata;
        r.cause = e_cause;
        resp_q.push_back(r);

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; bus_rdata = brd;
        got = 1'b0; lat = 0; reqc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus_req) reqc++;
            if (done) begin
                got = 1'b1;
                lat = c;
                break;
            end
            bus_ack = (c == ack_at);
        end
        bus_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (!got) begin
            check({name, "_done_seen"}, 32'd0, 32'd1);
        end else begin
            check({name, "_latency"}, lat, e_lat);
            check({name, "_req_cycles"}, reqc, e_reqc);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_rdata", rdata, 32'd0);
        check("rst_ctrl", {28'd0, busy, done, fault, bus_req}, 32'd0);
        check("rst_bus", {bus_addr[27:0], bus_be}, 32'd0);
        check("rst_bus2", bus_wdata ^ {31'd0, bus_we}, 32'd0);

        //        name   rd    wr    f3      addr          wdata         ack brdata        flt   cause   be       bus_wdata     rdata
        do_access("lw",  1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        3, 32'hDEAD_BEEF, 1'b0, C_NONE, 4'b1111, 32'h0,        32'hDEAD_BEEF);
        do_access("lb",  1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        1, 32'h8012_3456, 1'b0, C_NONE, 4'b1000, 32'h0,        32'hFFFF_FF80);
        do_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        2, 32'h8012_3456, 1'b0, C_NONE, 4'b1000, 32'h0,        32'h0000_0080);
        do_access("lh",  1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        1, 32'h8001_7FFF, 1'b0, C_NONE, 4'b1100, 32'h0,        32'hFFFF_8001);
        do_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        1, 32'h8001_7FFF, 1'b0, C_NONE, 4'b0011, 32'h0,        32'h0000_7FFF);
        do_access("sh",  1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 2, 32'h0,        1'b0, C_NONE, 4'b1100, 32'hABCD_ABCD, 32'h0);
        do_access("sb",  1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 1, 32'h0,        1'b0, C_NONE, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        do_access("sw",  1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 4, 32'h0,        1'b0, C_NONE, 4'b1111, 32'hCAFE_F00D, 32'h0);
        do_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,     0, 32'h5555_5555, 1'b1, C_MIS, 4'b0000, 32'h0,        32'h0);
        do_access("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0001, 32'h0,     0, 32'h5555_5555, 1'b1, C_MIS, 4'b0000, 32'h0,        32'h0);
        do_access("ld_ill", 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,     0, 32'h5555_5555, 1'b1, C_ILL, 4'b0000, 32'h0,        32'h0);
        do_access("st_ill", 1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,     0, 32'h0,        1'b1, C_ILL, 4'b0000, 32'h0,        32'h0);
        do_access("rd_wr",  1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,     0, 32'h0,        1'b1, C_ILL, 4'b0000, 32'h0,        32'h0);
        do_access("sw_tmo", 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0BAD_0BAD, 0, 32'h0,    1'b1, C_TMO, 4'b1111, 32'h0BAD_0BAD, 32'h0);
        do_access("sw_ack16", 1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h600D_600D, 16, 32'h0, 1'b0, C_NONE, 4'b1111, 32'h600D_600D, 32'h0);
        do_access("lw_tmo", 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0,     0, 32'h9999_9999, 1'b1, C_TMO, 4'b1111, 32'h0,        32'h0);
        do_access("lw_ack15", 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0,  15, 32'h7777_0001, 1'b0, C_NONE, 4'b1111, 32'h0,        32'h7777_0001);

        // Reset while BUS: no done may follow, and rdata returns to 0.
        begin
            bus_exp_t b;
            b.addr = 32'h0000_0080; b.be = 4'b1111; b.we = 1'b0; b.wdata = 32'h0; b.chk_wdata = 1'b0;
            bus_q.push_back(b);
            @(posedge clk); #1;
            mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0080; bus_rdata = 32'h1111_1111;
            @(posedge clk); #1;
            check("midrst_req_up", {31'd0, bus_req}, 32'd1);
            @(posedge clk); #1;
            reset = 1'b1; mem_read = 1'b0;
            @(posedge clk); #1;
            check("midrst_req_down", {31'd0, bus_req}, 32'd0);
            check("midrst_done", {30'd0, done, busy}, 32'd0);
            reset = 1'b0;
            exp_rdata = 32'd0;
            repeat (3) @(posedge clk);
            #1 check("midrst_rdata", rdata, 32'd0);
        end
        do_access("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1, 32'h1122_3344, 1'b0, C_NONE, 4'b1111, 32'h0, 32'h1122_3344);

        repeat (3) @(posedge clk);
        #1;
        check("bus_q_empty", bus_q.size(), 32'd0);
        check("resp_q_empty", resp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
